// File: rtl/gvp_stream_packer_if.sv
// AXI4-Stream link between the GVP stream packer and the DMA.
// The packer drives it through the master modport; the DMA side uses the slave modport.
interface gvp_stream_packer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/gvp_stream_packer.sv
// GVP store-trigger packer: snapshots GVP state on each store trigger, frames it into 32-bit
// words in a FWFT FIFO and streams them out. Optional trailing checksum: GVP_PACKER_CHECKSUM_EN.
module gvp_stream_packer #(
    parameter int FIFO_DEPTH_N2 = 6,
    parameter int STALL_MARGIN  = 24,
    parameter int NUM_SRCS      = 16
) (
    input  logic                     a_clk,
    input  logic                     reset,
    input  logic [1:0]               store_data,
    input  logic                     store_tick,
    input  logic [31:0]              options,
    input  logic [31:0]              index,
    input  logic [47:0]              gvp_time,
    input  logic [191:0]             vec_xyzuab,
    input  logic [NUM_SRCS*32-1:0]   src_data,
    gvp_stream_packer_if.master      m_axis,
    output logic                     stall,
    output logic                     overrun,
    output logic [31:0]              frame_count
);

    localparam int                   DEPTH    = 1 << FIFO_DEPTH_N2;
    localparam logic [FIFO_DEPTH_N2:0] DEPTH_C  = DEPTH[FIFO_DEPTH_N2:0];
    localparam logic [FIFO_DEPTH_N2:0] MARGIN_C = STALL_MARGIN[FIFO_DEPTH_N2:0];
    localparam logic [FIFO_DEPTH_N2:0] CNT_ONE  = {{FIFO_DEPTH_N2{1'b0}}, 1'b1};
    localparam logic [FIFO_DEPTH_N2-1:0] PTR_ONE = {{(FIFO_DEPTH_N2-1){1'b0}}, 1'b1};
`ifdef GVP_PACKER_CHECKSUM_EN
    localparam logic [4:0] CSUM_WORDS = 5'd1;
`else
    localparam logic [4:0] CSUM_WORDS = 5'd0;
`endif

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EMIT = 1'b1} state_t;

    function automatic logic [4:0] popcount16(input logic [15:0] m);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, m[i]};
        end
        return c;
    endfunction

    function automatic logic [3:0] lowest_set(input logic [15:0] m);
        logic [3:0] p;
        p = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) begin
                p = 4'(i);
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    state_t                 state_r, state_next_s;
    logic [1:0]             code_r;
    logic [15:0]            opts_r, mask_r;
    logic [31:0]            index_r;
    logic [47:0]            time_r;
    logic [191:0]           vec_r;
    logic [NUM_SRCS*32-1:0] src_r;
    logic [4:0]             n_r, idx_r;
    logic                   overrun_r, stall_r;
    logic [31:0]            frame_count_r;

    logic [32:0]              mem_r [DEPTH];
    logic [FIFO_DEPTH_N2-1:0] wr_ptr_r, rd_ptr_r;
    logic [FIFO_DEPTH_N2:0]   count_r;

    logic        trigger_s, capture_s, drop_s, push_s, pop_s, full_s, tvalid_s, frame_done_s;
    logic [4:0]  payload_len_s, last_idx_s;
    logic [3:0]  sel_s;
    logic [31:0] payload_word_s, word_s;
    logic [FIFO_DEPTH_N2:0] free_s;
    logic        unused_s;

    assign unused_s  = ^options[31:16];
    assign trigger_s = store_tick && (store_data != 2'd0);
    assign full_s    = (count_r == DEPTH_C);
    assign tvalid_s  = (count_r != {(FIFO_DEPTH_N2+1){1'b0}});
    assign pop_s     = tvalid_s && m_axis.tready;
    assign free_s    = DEPTH_C - count_r;
    assign sel_s     = lowest_set(mask_r);

    // Frame length from the captured store code.
    always_comb begin
        payload_len_s = 5'd1;
        case (code_r)
            2'd1:    payload_len_s = 5'd1 + n_r;
            2'd2:    payload_len_s = 5'd10;
            2'd3:    payload_len_s = 5'd4;
            default: payload_len_s = 5'd1;
        endcase
        last_idx_s = payload_len_s + CSUM_WORDS - 5'd1;
    end

    // Payload word selected by the word index within the current frame.
    always_comb begin
        payload_word_s = 32'h0000_0000;
        case (code_r)
            2'd1: begin
                if (idx_r == 5'd0) begin
                    payload_word_s = {8'hA1, 3'b000, n_r, opts_r};
                end else begin
                    payload_word_s = src_r[{sel_s, 5'd0} +: 32];
                end
            end
            2'd2: begin
                case (idx_r)
                    5'd0:    payload_word_s = {8'hA2, 8'h00, opts_r};
                    5'd1:    payload_word_s = index_r;
                    5'd2:    payload_word_s = time_r[31:0];
                    5'd3:    payload_word_s = {16'h0000, time_r[47:32]};
                    5'd4:    payload_word_s = vec_r[31:0];
                    5'd5:    payload_word_s = vec_r[63:32];
                    5'd6:    payload_word_s = vec_r[95:64];
                    5'd7:    payload_word_s = vec_r[127:96];
                    5'd8:    payload_word_s = vec_r[159:128];
                    5'd9:    payload_word_s = vec_r[191:160];
                    default: payload_word_s = 32'h0000_0000;
                endcase
            end
            2'd3: begin
                case (idx_r)
                    5'd0:    payload_word_s = 32'hA300_FFFF;
                    5'd1:    payload_word_s = index_r;
                    5'd2:    payload_word_s = time_r[31:0];
                    5'd3:    payload_word_s = {16'h0000, time_r[47:32]};
                    default: payload_word_s = 32'h0000_0000;
                endcase
            end
            default: payload_word_s = 32'h0000_0000;
        endcase
    end

`ifdef GVP_PACKER_CHECKSUM_EN
    logic [31:0] sum_r;
    assign word_s = (idx_r == payload_len_s) ? sum_r : payload_word_s;

    // Running wrap-around sum of the words already written in this frame.
    always_ff @(posedge a_clk) begin
        if (reset || capture_s) begin
            sum_r <= 32'h0000_0000;
        end else if (push_s) begin
            sum_r <= sum_r + word_s;
        end
    end
`else
    assign word_s = payload_word_s;
`endif

    // FSM state register.
    always_ff @(posedge a_clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: capture in IDLE, one word per cycle in EMIT while the FIFO has room.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        drop_s       = 1'b0;
        push_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_EMIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EMIT: begin
                drop_s = trigger_s;
                if (!full_s || pop_s) begin
                    push_s = 1'b1;
                    if (idx_r == last_idx_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_EMIT;
                    end
                end else begin
                    state_next_s = ST_EMIT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    assign frame_done_s = push_s && (idx_r == last_idx_s);

    // Snapshot registers, word sequencing and status outputs.
    always_ff @(posedge a_clk) begin
        if (reset) begin
            code_r        <= 2'd0;
            opts_r        <= 16'h0000;
            mask_r        <= 16'h0000;
            index_r       <= 32'h0000_0000;
            time_r        <= 48'h0000_0000_0000;
            vec_r         <= 192'h0;
            src_r         <= '0;
            n_r           <= 5'd0;
            idx_r         <= 5'd0;
            overrun_r     <= 1'b0;
            stall_r       <= 1'b0;
            frame_count_r <= 32'h0000_0000;
        end else begin
            if (capture_s) begin
                code_r  <= store_data;
                opts_r  <= options[15:0];
                mask_r  <= options[15:0];
                index_r <= index;
                time_r  <= gvp_time;
                vec_r   <= vec_xyzuab;
                src_r   <= src_data;
                n_r     <= popcount16(options[15:0]);
                idx_r   <= 5'd0;
            end else if (push_s) begin
                idx_r <= idx_r + 5'd1;
                // Each emitted source word retires the lowest remaining mask bit.
                if ((code_r == 2'd1) && (idx_r != 5'd0)) begin
                    mask_r <= mask_r & (mask_r - 16'h0001);
                end
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end
            if (frame_done_s) begin
                frame_count_r <= frame_count_r + 32'h0000_0001;
            end
            stall_r <= (free_s < MARGIN_C) || (state_r != ST_IDLE);
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge a_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {frame_done_s, word_s};
        end
    end

    // FIFO pointers and occupancy; a pop on a full FIFO frees the slot for a same-cycle push.
    always_ff @(posedge a_clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign m_axis.tvalid = tvalid_s;
    assign m_axis.tdata  = tvalid_s ? mem_r[rd_ptr_r][31:0] : 32'h0000_0000;
    assign m_axis.tlast  = tvalid_s ? mem_r[rd_ptr_r][32] : 1'b0;
    assign stall         = stall_r;
    assign overrun       = overrun_r;
    assign frame_count   = frame_count_r;

endmodule
